// File: rtl/synapse_sum_if.sv
// Handshake bundle between the weighted-sum stage and its neighbours: activation in, sum out,
// error in, per-input error out, plus the training-mode strobe.
interface synapse_sum_if;
    logic        train;
    logic        arg_valid;
    logic        arg_ready;
    logic [7:0]  arg_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        err_valid;
    logic        err_ready;
    logic [15:0] err_data;
    logic        fbk_valid;
    logic        fbk_ready;
    logic [15:0] fbk_data;

    modport master (
        output train, arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready,
        input  arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data
    );

    modport slave (
        input  train, arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready,
        output arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data
    );
endinterface

// File: rtl/synapse_sum.sv
// Weighted-sum stage: N serial Q0.8 activations times Q8.8 weights into a saturated Q8.8 sum,
// with in-place weight training from the downstream error. Define BIAS_EN for a trainable bias.
module synapse_sum #(
    parameter int N    = 4,
    parameter int RATE = 0
) (
    input  logic         clock,
    input  logic         reset,
    synapse_sum_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = 18 + $clog2(N + 1);
    localparam int SW = (AW > 32) ? AW : 32;
    localparam logic signed [SW-1:0] MAX16 = 32767;
    localparam logic signed [SW-1:0] MIN16 = -32768;

    typedef enum logic [1:0] {ACCUM, RESULT, WAIT_ERR, FEEDBACK} state_t;

    state_t               state;
    state_t               state_next;
    logic [IW-1:0]        index;
    logic signed [AW-1:0] acc;
    logic signed [15:0]   w [N];
    logic [7:0]           x [N];
    logic signed [15:0]   e;
    logic                 train_q;
    logic signed [15:0]   bias_q;

    logic                 last_beat;
    logic signed [15:0]   err_in;
    logic signed [24:0]   arg_prod;
    logic signed [AW-1:0] acc_next;
    logic signed [31:0]   fbk_prod;
    logic signed [24:0]   upd_prod;
    logic signed [15:0]   w_upd;

    function automatic logic signed [15:0] sat16(input logic signed [SW-1:0] v);
        if (v > MAX16)
            return 16'sh7fff;
        else if (v < MIN16)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // Shared datapath: one multiplier slot per phase, all indexed by the running beat counter.
    always_comb begin
        last_beat = (index == IW'(N - 1));
        err_in    = $signed(bus.err_data);
        arg_prod  = w[index] * $signed({1'b0, bus.arg_data});
        acc_next  = ((index == '0) ? AW'(bias_q) : acc) + AW'(arg_prod >>> 8);
        fbk_prod  = w[index] * e;
        upd_prod  = e * $signed({1'b0, x[index]});
        w_upd     = sat16(SW'(w[index]) + SW'(upd_prod >>> (8 + RATE)));
    end

    assign bus.res_data = sat16(SW'(acc));
    assign bus.fbk_data = sat16(SW'(fbk_prod >>> 8));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ACCUM;
        else
            state <= state_next;
    end

    // Handshake outputs depend on state only, so no valid/ready input reaches an output ready/valid.
    always_comb begin
        state_next    = state;
        bus.arg_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.err_ready = 1'b0;
        bus.fbk_valid = 1'b0;
        case (state)
            ACCUM: begin
                bus.arg_ready = reset;
                if (bus.arg_valid && last_beat)
                    state_next = RESULT;
            end
            RESULT: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready)
                    state_next = train_q ? WAIT_ERR : ACCUM;
            end
            WAIT_ERR: begin
                bus.err_ready = 1'b1;
                if (bus.err_valid)
                    state_next = FEEDBACK;
            end
            FEEDBACK: begin
                bus.fbk_valid = 1'b1;
                if (bus.fbk_ready && last_beat)
                    state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            index   <= '0;
            acc     <= '0;
            e       <= '0;
            train_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                w[i] <= '0;
                x[i] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.arg_valid) begin
                        acc      <= acc_next;
                        x[index] <= bus.arg_data;
                        if (index == '0)
                            train_q <= bus.train;
                        index <= last_beat ? '0 : index + IW'(1);
                    end
                end
                WAIT_ERR: begin
                    if (bus.err_valid) begin
                        e     <= err_in;
                        index <= '0;
                    end
                end
                FEEDBACK: begin
                    if (bus.fbk_ready) begin
                        w[index] <= w_upd;
                        index    <= last_beat ? '0 : index + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BIAS_EN
    // WAIT_ERR is only ever entered for a training sum, so every accepted error trains the bias.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            bias_q <= '0;
        else if (state == WAIT_ERR && bus.err_valid)
            bias_q <= sat16(SW'(bias_q) + SW'(err_in >>> RATE));
    end
`else
    assign bias_q = '0;
`endif

endmodule
